// File: rtl/hall_speed_sampler_pkg.sv
// Shared motor definitions: hall/position widths, default sample period and sampler state encodings.
package hall_speed_sampler_pkg;

  localparam int HALL_COUNT_W          = 8;
  localparam int POSITION_W            = 16;
  localparam int DEFAULT_SAMPLE_PERIOD = 50000;

  // Encodings are shared with the motor and SPI register blocks; keep them stable.
  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } sampler_state_t;

endpackage

// File: rtl/hall_speed_sampler_sample_timer.sv
// Prescaler for the hall sampler: emits a 1-cycle strobe every SAMPLE_PERIOD cycles while run is high.
module sample_timer
  import hall_speed_sampler_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic strobe
);

  localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(SAMPLE_PERIOD - 1);

  logic [TIMER_W-1:0] timer;

  // Held at zero outside RUN so the first strobe lands exactly SAMPLE_PERIOD cycles after PRIME.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      timer <= '0;
    end else if (timer == LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  assign strobe = run && (timer == LAST);

endmodule

// File: rtl/hall_speed_sampler.sv
// Samples a free-running hall count at a fixed rate; produces delta, position, speed, stall/fault flags
// behind a valid/ack handshake. Optional speed low-pass filter enabled by MOTOR_SPEED_FILTER_EN.
module hall_speed_sampler
  import hall_speed_sampler_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
  parameter int STALL_SAMPLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [HALL_COUNT_W-1:0] hall_count,
  input  logic                    fault,
  input  logic                    sample_ack,
  output logic                    sample_valid,
  output logic [HALL_COUNT_W-1:0] delta,
  output logic [POSITION_W-1:0]   position,
  output logic [HALL_COUNT_W-1:0] speed,
  output logic                    stalled,
  output logic                    fault_seen,
  output logic                    overrun
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef MOTOR_SPEED_FILTER_EN
  // acc += ((d << 4) - acc) >>> 2, widened to 13 bits so the difference cannot overflow.
  function automatic logic signed [11:0] filter_step(input logic signed [11:0] acc,
                                                     input logic signed [7:0]  d);
    logic signed [12:0] diff;
    logic signed [12:0] step;
    diff = $signed({d[7], d, 4'b0000}) - $signed({acc[11], acc});
    step = diff >>> 2;
    return acc + step[11:0];
  endfunction
`endif

  sampler_state_t state, state_next;
  logic           prime;
  logic           run;
  logic           strobe_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRIME;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    prime      = 1'b0;
    case (state)
      PRIME: begin
        prime      = 1'b1;
        state_next = RUN;
      end
      RUN: state_next = RUN;
    endcase
  end

  assign run = (state == RUN) && !reset;

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .strobe(strobe_p0)
  );

  // ---- p0: strobe cycle, combinational delta and stall bookkeeping ----
  logic        [7:0]  prev;
  logic        [7:0]  zero_run_p1;
  logic signed [7:0]  d_p0;
  logic        [7:0]  zero_run_next_p0;
  logic               ack_take_p0;

  logic               vld_p1;
  logic signed [7:0]  delta_p1;
  logic signed [15:0] position_p1;
  logic        [7:0]  speed_p1;
  logic               stalled_p1;
  logic               fault_seen_p1;
  logic               overrun_p1;

  assign d_p0             = $signed(hall_count - prev);
  assign zero_run_next_p0 = (d_p0 == 8'sd0) ? sat_inc(zero_run_p1) : 8'd0;
  assign ack_take_p0      = sample_ack && vld_p1;

`ifdef MOTOR_SPEED_FILTER_EN
  logic signed [11:0] acc_p1;
  logic signed [11:0] acc_next_p0;

  assign acc_next_p0 = filter_step(acc_p1, d_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p1 <= '0;
    end else if (strobe_p0) begin
      acc_p1 <= acc_next_p0;
    end
  end
`endif

  // ---- p1: registered sample and handshake flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      prev          <= '0;
      zero_run_p1   <= '0;
      vld_p1        <= 1'b0;
      delta_p1      <= '0;
      position_p1   <= '0;
      speed_p1      <= '0;
      stalled_p1    <= 1'b0;
      fault_seen_p1 <= 1'b0;
      overrun_p1    <= 1'b0;
    end else begin
      if (prime) begin
        prev <= hall_count;
      end

      if (strobe_p0) begin
        prev        <= hall_count;
        delta_p1    <= d_p0;
        position_p1 <= position_p1 + 16'(d_p0);
        zero_run_p1 <= zero_run_next_p0;
        stalled_p1  <= (zero_run_next_p0 >= 8'(STALL_SAMPLES));
`ifdef MOTOR_SPEED_FILTER_EN
        speed_p1    <= acc_next_p0[11:4];
`else
        speed_p1    <= d_p0;
`endif
        vld_p1      <= 1'b1;
        // A coincident ack consumes the old sample, so only an unacked overwrite is an overrun.
        if (ack_take_p0) begin
          overrun_p1 <= 1'b0;
        end else if (vld_p1) begin
          overrun_p1 <= 1'b1;
        end
      end else if (ack_take_p0) begin
        vld_p1     <= 1'b0;
        overrun_p1 <= 1'b0;
      end

      fault_seen_p1 <= ack_take_p0 ? fault : (fault_seen_p1 | fault);
    end
  end

  assign sample_valid = vld_p1;
  assign delta        = delta_p1;
  assign position     = position_p1;
  assign speed        = speed_p1;
  assign stalled      = stalled_p1;
  assign fault_seen   = fault_seen_p1;
  assign overrun      = overrun_p1;

endmodule
